multi_threshold_detector: RTL and testbench

- NUM_CH-channel onset/peak detector placed after the per-microphone filter outputs.
- Each channel opens a detection window when its sample exceeds HIGH, then tracks the peak value and the time of that peak.
- The window closes after a programmable run of consecutive samples below LOW (hysteresis).
- Each channel then reports {peak, time} through an independent valid/ack handshake against a shared sample-time counter, giving the downstream direction-of-arrival logic comparable timestamps.

---
 rtl/multi_threshold_detector_pkg.sv | 10 +
 rtl/multi_threshold_detector_channel.sv | 127 ++++++++++++
 rtl/multi_threshold_detector.sv | 67 ++++++
 tb/tb_multi_threshold_detector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multi_threshold_detector_pkg.sv
// rtl/multi_threshold_detector_pkg.sv - shared constants for the multi-channel onset/peak detector
package multi_threshold_detector_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_WINDOW = 1'b1;

  // A programmed quiet_len of zero still needs one quiet sample to close.
  localparam int unsigned QUIET_MIN = 1;

endpackage

// File: rtl/multi_threshold_detector_channel.sv
// rtl/multi_threshold_detector_channel.sv - one channel: window FSM, peak tracking, event holding register
module threshold_channel
  import multi_threshold_detector_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIME_W  = 32,
  parameter int QUIET_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_valid,
  input  logic [DATA_W-1:0]  data,
  input  logic [DATA_W-1:0]  high,
  input  logic [DATA_W-1:0]  low,
  input  logic [QUIET_W-1:0] quiet_len,
  input  logic [TIME_W-1:0]  timer,
  input  logic               ack,
  output logic               evt_valid,
  output logic [DATA_W-1:0]  evt_peak,
  output logic [TIME_W-1:0]  evt_time,
  output logic               overflow
);

  logic [0:0]         state_q, state_d;
  logic [DATA_W-1:0]  peak_q, peak_d;
  logic [TIME_W-1:0]  ptime_q, ptime_d;
  logic [QUIET_W-1:0] qcnt_q, qcnt_d;
  logic               evt_valid_q, evt_valid_d;
  logic [DATA_W-1:0]  evt_peak_q, evt_peak_d;
  logic [TIME_W-1:0]  evt_time_q, evt_time_d;
  logic               overflow_q, overflow_d;

  logic [QUIET_W-1:0] quiet_eff;
  logic [QUIET_W:0]   qcnt_next;
  logic               close;
  logic               consume;

  assign quiet_eff = (quiet_len == '0) ? QUIET_W'(QUIET_MIN) : quiet_len;
  // One extra bit so the close compare is still correct when qcnt is saturated.
  assign qcnt_next = {1'b0, qcnt_q} + (QUIET_W+1)'(1);
  assign consume   = ack & evt_valid_q;

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    ptime_d = ptime_q;
    qcnt_d  = qcnt_q;
    close   = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (data > high) begin
            peak_d  = data;
            ptime_d = timer;
            qcnt_d  = '0;
            state_d = ST_WINDOW;
          end
        end
        default: begin
          if (data > high) begin
            qcnt_d = '0;
            if (data > peak_q) begin
              peak_d  = data;
              ptime_d = timer;
            end
          end else if (data >= low) begin
            qcnt_d = '0;
          end else begin
            qcnt_d = (&qcnt_q) ? qcnt_q : qcnt_next[QUIET_W-1:0];
            if (qcnt_next >= {1'b0, quiet_eff}) begin
              close   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_peak_d  = evt_peak_q;
    evt_time_d  = evt_time_q;
    overflow_d  = overflow_q;
    if (consume) begin
      evt_valid_d = 1'b0;
    end
    // A pending event wins over a new one unless it is being acked this cycle.
    if (close) begin
      if (!evt_valid_q || consume) begin
        evt_valid_d = 1'b1;
        evt_peak_d  = peak_q;
        evt_time_d  = ptime_q;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      peak_q      <= '0;
      ptime_q     <= '0;
      qcnt_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_peak_q  <= '0;
      evt_time_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      ptime_q     <= ptime_d;
      qcnt_q      <= qcnt_d;
      evt_valid_q <= evt_valid_d;
      evt_peak_q  <= evt_peak_d;
      evt_time_q  <= evt_time_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_peak  = evt_peak_q;
  assign evt_time  = evt_time_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/multi_threshold_detector.sv
// rtl/multi_threshold_detector.sv - shared sample-time counter plus NUM_CH independent detector channels
module multi_threshold_detector
  import multi_threshold_detector_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int TIME_W  = 32,
  parameter int QUIET_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DATA_W-1:0]   data,
  input  logic                       data_valid,
  input  logic [DATA_W-1:0]          high,
  input  logic [DATA_W-1:0]          low,
  input  logic [QUIET_W-1:0]         quiet_len,
  input  logic [NUM_CH-1:0]          ack,
  output logic [NUM_CH-1:0]          evt_valid,
  output logic [NUM_CH*TIME_W-1:0]   evt_time,
  output logic [NUM_CH*DATA_W-1:0]   evt_peak,
  output logic [NUM_CH-1:0]          overflow,
  output logic [TIME_W-1:0]          timer
);

  logic [TIME_W-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (data_valid) begin
      timer_d = timer_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer = timer_q;

  // Every channel stamps with the pre-increment timer so timestamps line up across channels.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    threshold_channel #(
      .DATA_W (DATA_W),
      .TIME_W (TIME_W),
      .QUIET_W(QUIET_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .data_valid(data_valid),
      .data      (data[c*DATA_W +: DATA_W]),
      .high      (high),
      .low       (low),
      .quiet_len (quiet_len),
      .timer     (timer_q),
      .ack       (ack[c]),
      .evt_valid (evt_valid[c]),
      .evt_peak  (evt_peak[c*DATA_W +: DATA_W]),
      .evt_time  (evt_time[c*TIME_W +: TIME_W]),
      .overflow  (overflow[c])
    );
  end

endmodule

// File: tb/tb_multi_threshold_detector.sv
// tb/tb_multi_threshold_detector.sv - scoreboard bench for multi_threshold_detector
module tb_multi_threshold_detector;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int TIME_W  = 4;
  localparam int QUIET_W = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] data = '0;
  logic                     data_valid = 1'b0;
  logic [DATA_W-1:0]        high = 32'd100;
  logic [DATA_W-1:0]        low = 32'd20;
  logic [QUIET_W-1:0]       quiet_len = 16'd3;
  logic [NUM_CH-1:0]        ack = '0;
  logic [NUM_CH-1:0]        evt_valid;
  logic [NUM_CH*TIME_W-1:0] evt_time;
  logic [NUM_CH*DATA_W-1:0] evt_peak;
  logic [NUM_CH-1:0]        overflow;
  logic [TIME_W-1:0]        timer;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] peak;
    logic [TIME_W-1:0] t;
  } exp_evt_t;

  exp_evt_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  multi_threshold_detector #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .TIME_W (TIME_W),
    .QUIET_W(QUIET_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .data_valid(data_valid),
    .high      (high),
    .low       (low),
    .quiet_len (quiet_len),
    .ack       (ack),
    .evt_valid (evt_valid),
    .evt_time  (evt_time),
    .evt_peak  (evt_peak),
    .overflow  (overflow),
    .timer     (timer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic tick(input logic [NUM_CH-1:0] mask, input logic [DATA_W-1:0] val,
                      input logic v, input logic [NUM_CH-1:0] a);
    for (int c = 0; c < NUM_CH; c++) data[c*DATA_W +: DATA_W] = mask[c] ? val : '0;
    data_valid = v;
    ack        = a;
    @(negedge clk);
    data_valid = 1'b0;
    ack        = '0;
  endtask

  task automatic stream(input logic [NUM_CH-1:0] mask, input logic [DATA_W-1:0] vals[$]);
    foreach (vals[i]) tick(mask, vals[i], 1'b1, '0);
  endtask

  task automatic push_evt(input int ch, input logic [DATA_W-1:0] pk, input logic [TIME_W-1:0] t);
    exp_evt_t e;
    e.ch = ch; e.peak = pk; e.t = t;
    sb.push_back(e);
  endtask

  task automatic pop_evt();
    exp_evt_t e;
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check($sformatf("ch%0d_valid", e.ch), 64'(evt_valid[e.ch]), 64'd1);
    check($sformatf("ch%0d_peak", e.ch), 64'(evt_peak[e.ch*DATA_W +: DATA_W]), 64'(e.peak));
    check($sformatf("ch%0d_time", e.ch), 64'(evt_time[e.ch*TIME_W +: TIME_W]), 64'(e.t));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick('0, '0, 1'b0, '0);
    tick('0, '0, 1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(evt_valid), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_timer"}, 64'(timer), 64'd0);
    check({tag, "_peak_or"}, 64'(|evt_peak), 64'd0);
    check({tag, "_time_or"}, 64'(|evt_time), 64'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // Basic event on ch0
    high = 100; low = 20; quiet_len = 3;
    stream(4'b0001, '{0, 150, 300, 200, 10, 10});
    check("basic_early_valid", 64'(evt_valid), 64'd0);
    push_evt(0, 300, 2);
    tick(4'b0001, 10, 1'b1, '0);
    check("basic_valid_vec", 64'(evt_valid), 64'b0001);
    pop_evt();
    tick('0, '0, 1'b0, 4'b0001);
    check("basic_ack_clear", 64'(evt_valid), 64'd0);

    // Hysteresis: the mid-window 50 restarts the quiet run
    do_reset();
    stream(4'b0010, '{150, 10, 10, 50, 10, 10});
    check("hyst_no_early_close", 64'(evt_valid), 64'd0);
    push_evt(1, 150, 0);
    tick(4'b0010, 10, 1'b1, '0);
    check("hyst_valid_vec", 64'(evt_valid), 64'b0010);
    pop_evt();
    tick('0, '0, 1'b0, 4'b0010);

    // Tie keeps the earliest time; two channels close together
    do_reset();
    stream(4'b1100, '{200, 200, 0, 0});
    push_evt(2, 200, 0);
    push_evt(3, 200, 0);
    tick(4'b1100, 0, 1'b1, '0);
    check("tie_valid_vec", 64'(evt_valid), 64'b1100);
    pop_evt();
    pop_evt();
    tick('0, '0, 1'b0, 4'b1100);
    check("tie_ack_clear", 64'(evt_valid), 64'd0);

    // Overflow: second close while first is pending
    do_reset();
    push_evt(0, 150, 0);
    stream(4'b0001, '{150, 10, 10, 10});
    check("ovf_first_clean", 64'(overflow), 64'd0);
    stream(4'b0001, '{250, 10, 10, 10});
    check("ovf_flag", 64'(overflow), 64'b0001);
    pop_evt();
    tick('0, '0, 1'b0, 4'b0001);
    check("ovf_ack_clear", 64'(evt_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'b0001);

    // Ack coincident with close, quiet_len=0 acting as 1
    do_reset();
    quiet_len = 0;
    push_evt(0, 150, 0);
    stream(4'b0001, '{150, 10});
    pop_evt();
    tick(4'b0001, 180, 1'b1, '0);
    push_evt(0, 180, 2);
    tick(4'b0001, 10, 1'b1, 4'b0001);
    pop_evt();
    check("coinc_no_ovf", 64'(overflow), 64'd0);
    tick('0, '0, 1'b0, 4'b0001);
    quiet_len = 3;

    // Reset mid-window discards the window
    do_reset();
    stream(4'b0001, '{200, 200});
    rst = 1'b1;
    tick(4'b0001, 10, 1'b1, '0);
    rst = 1'b0;
    check_all_zero("rst_mid");
    stream(4'b0001, '{10, 10, 10});
    check("rst_mid_no_evt", 64'(evt_valid), 64'd0);

    // Timer wrap at TIME_W=4; data == high does not open
    do_reset();
    for (int i = 0; i < 13; i++) tick(4'b0001, 100, 1'b1, '0);
    stream(4'b0001, '{10, 10, 10});
    check("eq_high_no_open", 64'(evt_valid), 64'd0);
    check("wrap_timer0", 64'(timer), 64'd0);
    tick(4'b0001, 150, 1'b1, '0);
    check("wrap_timer1", 64'(timer), 64'd1);
    push_evt(0, 150, 0);
    stream(4'b0001, '{10, 10, 10});
    pop_evt();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
